// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 keyboard frame receiver with a show-ahead scancode FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       C_LAST_BIT = 4'd10;

    // Synchronizers: the third clock stage is the previous sample for edge detect.
    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
    logic ps2_data_s1_q, ps2_data_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_s1_q  <= 1'b1;
            ps2_clk_s2_q  <= 1'b1;
            ps2_clk_s3_q  <= 1'b1;
            ps2_data_s1_q <= 1'b1;
            ps2_data_s2_q <= 1'b1;
        end else begin
            ps2_clk_s1_q  <= ps2_clk;
            ps2_clk_s2_q  <= ps2_clk_s1_q;
            ps2_clk_s3_q  <= ps2_clk_s2_q;
            ps2_data_s1_q <= ps2_data;
            ps2_data_s2_q <= ps2_data_s1_q;
        end
    end

    logic w_ps2_fall;
    assign w_ps2_fall = ps2_clk_s3_q & ~ps2_clk_s2_q;

    // Frame assembly and timeout
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            frame_err_q, frame_err_d;
    logic            w_frame_ok;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        frame_err_d = 1'b0;
        w_frame_ok  = 1'b0;
        if (w_ps2_fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == C_LAST_BIT) begin
                // Buffer holds start in [0], data in [8:1], parity in [9]; stop is live.
                bit_cnt_d = 4'd0;
                if (!shift_q[0] && ps2_data_s2_q && (^shift_q[9:1]))
                    w_frame_ok = 1'b1;
                else
                    frame_err_d = 1'b1;
            end else begin
                shift_d   = {ps2_data_s2_q, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == C_TO_LAST) begin
                to_cnt_d    = '0;
                bit_cnt_d   = 4'd0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= 4'd0;
            shift_q     <= 10'd0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Show-ahead FIFO
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             w_pop, w_push, w_full;

    assign w_full = (count_q == C_FULL_CNT);
    assign w_pop  = ~nextdata_n & (count_q != '0);
    // A pop in the same cycle frees the slot the full-FIFO write needs.
    assign w_push = w_frame_ok & (~w_full | w_pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (w_frame_ok & w_full & ~w_pop);
        if (w_push) begin
            mem_d[wr_ptr_q] = shift_q[8:1];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign data      = mem_q[rd_ptr_q];
    assign ready     = (count_q != '0);
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard_rx
// Description : Directed self-checking bench for ps2_keyboard_rx (scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready, overflow, frame_err;

    int vectors = 0;
    int miscompares = 0;
    int err_pulses = 0;
    int err_cycles = 0;
    logic err_prev = 1'b0;
    logic [7:0] sb[$];

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_cycles++;
        if (frame_err === 1'b1 && err_prev !== 1'b1) err_pulses++;
        err_prev <= frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_flip,
                                             input logic stop);
        return {stop, (~^b) ^ par_flip, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    // mode 0: plain; 1: latency check on stop edge; 2: pop exactly in the push cycle
    task automatic send_frame(input logic [10:0] f, input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) begin
            if (i == 10 && mode != 0) begin
                ps2_data = f[10];
                tick(HALF);
                ps2_clk = 1'b0;
                if (mode == 1) begin
                    @(posedge clk); #1;
                    chk("lat_early_ready", ready, 1'b0);
                    repeat (3) @(posedge clk); #1;
                    chk("lat_ready", ready, 1'b1);
                    chk("lat_data", data, (sb.size() > 0) ? sb[0] : 8'hEE);
                end else begin
                    @(posedge clk);
                    @(posedge clk); #2;
                    chk("popw_head", data, (sb.size() > 0) ? sb[0] : 8'hEE);
                    if (sb.size() > 0) void'(sb.pop_front());
                    nextdata_n = 1'b0;
                    @(posedge clk); #2;
                    nextdata_n = 1'b1;
                end
                tick(HALF);
                ps2_clk = 1'b1;
            end else begin
                ps2_bit(f[i]);
            end
        end
        tick(HALF);
    endtask

    task automatic pop_expect(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready"}, ready, 1'b1);
        chk({tag, "_data"}, data, (sb.size() > 0) ? sb.pop_front() : 8'hEE);
        nextdata_n = 1'b0;
        @(posedge clk); #2;
        nextdata_n = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
    endtask

    initial begin
        int ep, ec;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_ready", ready, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_data", data, 8'h00);

        // Basic receive with stop-edge latency, then single pop
        sb.push_back(8'h1C);
        send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1);
        pop_expect("t1_pop");
        chk("t1_empty", ready, 1'b0);

        // Bad parity, then bad stop
        ep = err_pulses; ec = err_cycles;
        send_frame(mk_frame(8'h1C, 1'b1, 1'b1), 11, 0);
        chk("t2_par_pulses", err_pulses - ep, 1);
        chk("t2_par_cycles", err_cycles - ec, 1);
        chk("t2_par_ready", ready, 1'b0);
        send_frame(mk_frame(8'h1C, 1'b0, 1'b0), 11, 0);
        chk("t2_stop_pulses", err_pulses - ep, 2);
        chk("t2_stop_cycles", err_cycles - ec, 2);
        chk("t2_stop_ready", ready, 1'b0);

        // Timeout on a partial frame, then a good frame
        ep = err_pulses;
        send_frame(mk_frame(8'hF0, 1'b0, 1'b1), 5, 0);
        tick(TIMEOUT + 10);
        chk("t4_timeout_pulse", err_pulses - ep, 1);
        sb.push_back(8'hF0);
        send_frame(mk_frame(8'hF0, 1'b0, 1'b1), 11, 0);
        chk("t4_no_err", err_pulses - ep, 1);
        pop_expect("t4_pop");
        chk("t4_empty", ready, 1'b0);

        // Fill, overflow, drain
        for (int i = 1; i <= DEPTH; i++) begin
            sb.push_back(8'(i));
            send_frame(mk_frame(8'(i), 1'b0, 1'b1), 11, 0);
        end
        chk("t3_full_ready", ready, 1'b1);
        chk("t3_full_ovf", overflow, 1'b0);
        send_frame(mk_frame(8'h09, 1'b0, 1'b1), 11, 0);
        chk("t3_ovf_set", overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++) pop_expect("t3_drain");
        chk("t3_empty", ready, 1'b0);
        chk("t3_ovf_sticky", overflow, 1'b1);

        // Streaming with immediate pops across two pointer wraps
        do_reset();
        chk("t5_ovf_cleared", overflow, 1'b0);
        for (int i = 8'h10; i <= 8'h23; i++) begin
            sb.push_back(8'(i));
            send_frame(mk_frame(8'(i), 1'b0, 1'b1), 11, 0);
            pop_expect("t5_stream");
        end
        chk("t5_empty", ready, 1'b0);
        chk("t5_ovf", overflow, 1'b0);

        // Full FIFO with a pop coinciding with the write
        for (int i = 8'h30; i <= 8'h37; i++) begin
            sb.push_back(8'(i));
            send_frame(mk_frame(8'(i), 1'b0, 1'b1), 11, 0);
        end
        sb.push_back(8'h38);
        send_frame(mk_frame(8'h38, 1'b0, 1'b1), 11, 2);
        chk("t5b_ovf", overflow, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop_expect("t5b_drain");
        chk("t5b_empty", ready, 1'b0);

        // Reset mid-frame, then a clean frame
        ep = err_pulses;
        send_frame(mk_frame(8'h77, 1'b0, 1'b1), 6, 0);
        rst_n = 1'b0;
        tick(2);
        chk("t6_ready_in_rst", ready, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(TIMEOUT + 10);
        chk("t6_no_err_after_rst", err_pulses - ep, 0);
        chk("t6_ready_after_rst", ready, 1'b0);
        sb.push_back(8'h5A);
        send_frame(mk_frame(8'h5A, 1'b0, 1'b1), 11, 0);
        pop_expect("t6_pop");
        chk("t6_empty", ready, 1'b0);
        chk("t6_no_err", err_pulses - ep, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
